// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the 7-segment scan driver
// Contents:
//   NUM_DIGITS   number of multiplexed digits on the board
//   SEG_OFF      active-low cathode pattern with every segment dark
//   scan_state_e LOAD -> ON -> DEAD scan states
//   HEX7_TABLE   active-high {g,f,e,d,c,b,a} glyphs for nibbles 0..F
package seg_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [6:0] SEG_OFF    = 7'h7F;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ON   = 2'd1,
    ST_DEAD = 2'd2
  } scan_state_e;

  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex7_decoder.sv
// rtl/hex7_decoder.sv - combinational hex nibble to 7-segment glyph decoder
// Ports:
//   nibble_i  in   4  hex value to display
//   seg_o     out  7  segments {g,f,e,d,c,b,a}, active high
module hex7_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX7_TABLE[nibble_i];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed 8-digit 7-segment driver with blink and dead time
// Ports:
//   clk          in   1   system clock
//   rst          in   1   asynchronous active-high reset
//   seg_content  in   32  nibble i shown on digit i
//   seg_dp       in   8   decimal point enable per digit
//   seg_en       in   8   digit enable per digit
//   seg_blink    in   8   blink enable per digit
//   an_n         out  8   anode selects, active low
//   seg_n        out  7   cathodes {g,f,e,d,c,b,a}, active low
//   dp_n         out  1   decimal-point cathode, active low
//   frame_start  out  1   one-cycle pulse in the digit-0 LOAD cycle
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 2,
  parameter int DEAD_CYCLES  = 1,
  parameter int BLINK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seg_content,
  input  logic [7:0]  seg_dp,
  input  logic [7:0]  seg_en,
  input  logic [7:0]  seg_blink,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_start
);

  localparam int SLOT_MAX = (DIGIT_CYCLES > DEAD_CYCLES) ? DIGIT_CYCLES : DEAD_CYCLES;
  localparam int CNT_W    = $clog2(SLOT_MAX + 1);
  localparam int BLINK_W  = $clog2(BLINK_CYCLES + 1);

  localparam logic [CNT_W-1:0]   ON_LAST    = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  scan_state_e        state_q;
  logic [2:0]         idx_q;
  logic [CNT_W-1:0]   cnt_q;
  // Reset parks the FSM in LOAD without having done the LOAD work; the first
  // edge after release performs the digit-0 capture and frame_start pulse.
  logic               armed_q;

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  logic [31:0]        content_q;
  logic [7:0]         dp_q;
  logic [7:0]         en_q;
  logic [7:0]         blink_q;

  logic [7:0]         an_q;
  logic [6:0]         seg_q;
  logic               dpn_q;
  logic               frame_q;

  logic [3:0]         nibble;
  logic [6:0]         glyph;
  logic               lit;
  logic               to_load;
  logic               capture;

  hex7_decoder u_hex7 (
    .nibble_i (nibble),
    .seg_o    (glyph)
  );

  always_comb begin
    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_comb begin
    nibble  = content_q[{idx_q, 2'b00} +: 4];
    lit     = en_q[idx_q] && !(blink_q[idx_q] && blink_phase_q);
    // Leaving the slot: from DEAD, or straight from ON when there is no dead time.
    to_load = armed_q &&
              (((state_q == ST_ON) && (cnt_q == ON_LAST) && (DEAD_CYCLES == 0)) ||
               ((state_q == ST_DEAD) && (cnt_q == DEAD_LAST)));
    // Snapshot is only taken when entering the digit-0 LOAD so a frame never tears.
    capture = !armed_q || (to_load && (idx_q == 3'd7));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      idx_q         <= '0;
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      content_q     <= '0;
      dp_q          <= '0;
      en_q          <= '0;
      blink_q       <= '0;
      an_q          <= 8'hFF;
      seg_q         <= SEG_OFF;
      dpn_q         <= 1'b1;
      frame_q       <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;

      an_q    <= 8'hFF;
      seg_q   <= SEG_OFF;
      dpn_q   <= 1'b1;
      frame_q <= capture;

      if (capture) begin
        content_q <= seg_content;
        dp_q      <= seg_dp;
        en_q      <= seg_en;
        blink_q   <= seg_blink;
      end

      if (!armed_q) begin
        armed_q <= 1'b1;
      end else if (to_load) begin
        state_q <= ST_LOAD;
        idx_q   <= idx_q + 3'd1;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_LOAD: begin
            state_q <= ST_ON;
            cnt_q   <= '0;
            if (lit) begin
              an_q  <= ~(8'b1 << idx_q);
              seg_q <= ~glyph;
              dpn_q <= ~dp_q[idx_q];
            end
          end
          ST_ON: begin
            if (cnt_q == ON_LAST) begin
              state_q <= ST_DEAD;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (lit) begin
                an_q  <= ~(8'b1 << idx_q);
                seg_q <= ~glyph;
                dpn_q <= ~dp_q[idx_q];
              end
            end
          end
          ST_DEAD: begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          default: begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign an_n        = an_q;
  assign seg_n       = seg_q;
  assign dp_n        = dpn_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk;
  logic        rst;
  logic [31:0] seg_content;
  logic [7:0]  seg_dp;
  logic [7:0]  seg_en;
  logic [7:0]  seg_blink;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_start;

  int errors;
  int checks;
  int cyc;
  int frame_no;

  seg_scan_driver #(
    .DIGIT_CYCLES (2),
    .DEAD_CYCLES  (1),
    .BLINK_CYCLES (500)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_content (seg_content),
    .seg_dp      (seg_dp),
    .seg_en      (seg_en),
    .seg_blink   (seg_blink),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Walks ncyc cycles from a digit-0 LOAD, checking {frame_start, an_n, seg_n, dp_n}.
  // Slot layout at defaults: pos 0 LOAD, pos 1-2 ON, pos 3 DEAD.
  task automatic run_frame(input logic [31:0] content, input logic [7:0] en,
                           input logic [7:0] dp, input logic [7:0] blink,
                           input int ncyc, input int mid_k, input logic [31:0] mid_val);
    int         slot;
    int         pos;
    logic       dark;
    logic [3:0] nib;
    logic [16:0] exp;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      slot = k / 4;
      pos  = k % 4;
      nib  = content[4*slot +: 4];
      dark = blink[slot] && ((cyc % 1000) >= 500);
      exp  = {(pos == 0) && (slot == 0), 8'hFF, 7'h7F, 1'b1};
      if ((pos == 1 || pos == 2) && en[slot] && !dark)
        exp = {1'b0, ~(8'b1 << slot), ~HEX[nib], ~dp[slot]};
      check($sformatf("frame%0d cyc%0d", frame_no, k),
            32'({frame_start, an_n, seg_n, dp_n}), 32'(exp));
      if (k == mid_k) seg_content = mid_val;
      cyc++;
    end
    frame_no++;
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    cyc         = 0;
    frame_no    = 0;
    rst         = 1'b1;
    seg_content = 32'h76543210;
    seg_dp      = 8'h00;
    seg_en      = 8'hFF;
    seg_blink   = 8'h00;

    repeat (3) @(negedge clk);
    check("reset an_n", 32'(an_n), 32'h0FF);
    check("reset seg_n", 32'(seg_n), 32'h07F);
    check("reset dp_n", 32'(dp_n), 32'h1);
    check("reset frame_start", 32'(frame_start), 32'h0);

    // Basic scan of 0..7
    rst = 1'b0;
    cyc = 0;
    run_frame(32'h76543210, 8'hFF, 8'h00, 8'h00, 32, -1, 32'h0);

    // Mid-frame content change during digit 3 ON is held off until next frame
    run_frame(32'h76543210, 8'hFF, 8'h00, 8'h00, 32, 13, 32'hFFFFFFFF);
    run_frame(32'hFFFFFFFF, 8'hFF, 8'h00, 8'h00, 32, -1, 32'h0);

    // Upper four digits disabled
    seg_content = 32'h76543210;
    seg_en      = 8'h0F;
    run_frame(32'h76543210, 8'h0F, 8'h00, 8'h00, 32, -1, 32'h0);

    // Decimal point on digit 2 only
    seg_en = 8'hFF;
    seg_dp = 8'h04;
    run_frame(32'h76543210, 8'hFF, 8'h04, 8'h00, 32, -1, 32'h0);

    // Digit 0 blinking across a full dark half-period and back
    seg_dp    = 8'h00;
    seg_blink = 8'h01;
    while (cyc < 1100)
      run_frame(32'h76543210, 8'hFF, 8'h00, 8'h01, 32, -1, 32'h0);

    // Reset asserted during digit 5 ON
    seg_blink = 8'h00;
    run_frame(32'h76543210, 8'hFF, 8'h00, 8'h00, 22, -1, 32'h0);
    seg_content = 32'h89ABCDEF;
    #2 rst = 1'b1;
    #1;
    check("midreset an_n", 32'(an_n), 32'h0FF);
    check("midreset seg_n", 32'(seg_n), 32'h07F);
    check("midreset dp_n", 32'(dp_n), 32'h1);
    check("midreset frame_start", 32'(frame_start), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    run_frame(32'h89ABCDEF, 8'hFF, 8'h00, 8'h00, 32, -1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Consumer end of the 7-segment display interface that the clock/timer/alarm blocks produce: seg_content (8 hex nibbles), seg_dp and seg_en.
- Time-multiplexes the 8 digits onto the board's shared active-low cathode bus and active-low anodes.
- Supports per-digit blinking and a dead-time gap between digits against ghosting.
- Sits between digital_clock outputs and the board pins.

Parameters:
- DIGIT_CYCLES, 2, clk cycles each digit is driven (ON state); must be >= 1.
- DEAD_CYCLES, 1, clk cycles all digits are off after each ON slot; 0 skips the DEAD state.
- BLINK_CYCLES, 500, clk cycles per blink half-period (0.5 s at 1 kHz); must be >= 1.

Ports:
- clk  in  1  system clock (1 kHz on board)
- rst  in  1  asynchronous active-high reset
- seg_content  in  32  nibble i = seg_content[4i+3:4i] shown on digit i
- seg_dp  in  8  bit i=1 lights the decimal point of digit i
- seg_en  in  8  bit i=1 enables digit i
- seg_blink  in  8  bit i=1 makes digit i blink
- an_n  out  8  anode selects, active low, bit i = digit i
- seg_n  out  7  cathodes {g,f,e,d,c,b,a}, active low
- dp_n  out  1  decimal-point cathode, active low
- frame_start  out  1  one-cycle pulse in the LOAD cycle of digit 0

Behaviour:
- Reset (async, immediate):
  - Outputs: an_n=8'hFF, seg_n=7'h7F, dp_n=1, frame_start=0.
  - State: idx=0, FSM=LOAD, blink counter=0, blink_phase=0 (visible), snapshot registers=0.
- FSM states: LOAD -> ON -> DEAD -> LOAD.
  - LOAD: lasts 1 cycle; all outputs off. If idx==0, capture seg_content/dp/en/blink into the snapshot and pulse frame_start.
  - ON: lasts DIGIT_CYCLES cycles; drives digit idx from the snapshot.
  - DEAD: lasts DEAD_CYCLES cycles; all outputs off. On exit, idx = idx+1 mod 8 (7 wraps to 0). With DEAD_CYCLES=0, ON goes directly to LOAD and idx increments on that transition.
- Timing:
  - Per-digit slot = 1+DIGIT_CYCLES+DEAD_CYCLES cycles; frame = 8 slots (32 cycles at defaults).
  - All outputs are registered and change in the same cycle as the state register, so the first ON cycle already shows the digit.
- Lit condition in ON: en_snap[idx] && !(blink_snap[idx] && blink_phase).
  - If lit: an_n = ~(8'b1<<idx), seg_n = ~hex7(nibble), dp_n = ~dp_snap[idx].
  - If not lit: an_n=8'hFF, seg_n=7'h7F, dp_n=1. Slot timing is unchanged.
- hex7 encoding (gfedcba, active high):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Blink: a free-running counter 0..BLINK_CYCLES-1, independent of the scan; blink_phase toggles on each wrap.
- Snapshot rule: input changes mid-frame are ignored until the next digit-0 LOAD, so a frame never tears.
- seg_en=0 everywhere: scanning and frame_start continue; anodes stay high.
- Reset asserted mid-frame: outputs off immediately; after release the scan restarts at LOAD idx 0 with a fresh snapshot.

Decomposition:
- Package seg_pkg holds:
  - the FSM state enum (LOAD/ON/DEAD);
  - the 16-entry hex7 constant table;
  - the constants NUM_DIGITS=8 and SEG_OFF=7'h7F.
- Natural sub-module: hex7_decoder, a combinational 4-bit -> 7-bit active-high decoder; the top level inverts its output.
- Counters and FSM stay in seg_scan_driver.

Test Plan:
1. Reset, then seg_content=32'h76543210, seg_en=8'hFF, seg_dp=0, seg_blink=0 (defaults).
   - Cycle 0: LOAD with frame_start=1, outputs off.
   - Cycles 1-2: an_n=FE, seg_n=7'h40.
   - Cycle 3: all off.
   - Cycles 5-6: an_n=FD, seg_n=7'h79.
   - Digit 7 (cycles 29-30): an_n=7F, seg_n=7'h78. frame_start recurs at cycle 32.
2. Snapshot: change seg_content to 32'hFFFFFFFF during digit 3 ON.
   - Digits 3-7 still show 3..7.
   - The next frame shows seg_n=7'h0E on every digit.
3. seg_en=8'h0F -> an_n=FF during the ON slots of digits 4-7; digits 0-3 are unchanged; frame length stays 32.
4. seg_dp=8'h04 -> dp_n=0 only during digit 2 ON cycles; 1 at all other times.
5. seg_blink=8'h01, BLINK_CYCLES=500.
   - Digit 0 is lit in its slots during cycles 0-499 and dark during 500-999, repeating.
   - Digits 1-7 are unaffected.
6. Assert rst during digit 5 ON.
   - Same cycle: an_n=FF, seg_n=7F, dp_n=1.
   - After release: LOAD idx 0 with frame_start=1, and the new seg_content is captured.
